pixel_line_feeder: RTL and testbench
====================================

# pixel_line_feeder

Parametrised, double-buffered successor to the single-row pixel feeder. It reads a low-resolution framebuffer row by row over a request/acknowledge memory port into two ping-pong line banks. It replicates each stored pixel SCALE_X times horizontally and each row SCALE_Y times vertically, and drives the VGA pixel stream. The whole block sits between the framebuffer memory arbiter and the video timing generator, entirely in the clk_25 domain.

## Interface
- PIX_W, 4, bits per pixel
- COLS, 64, framebuffer columns (power of two)
- ROWS, 48, framebuffer rows
- SCALE_X, 10, horizontal replication factor (≥2)
- SCALE_Y, 10, vertical replication factor (≥1)
- PIX_PER_WORD, 8, pixels per memory word (power of two, divides COLS)
- Derived widths: ADDR_W = $clog2(COLS*ROWS/PIX_PER_WORD) (9 at defaults); SEL_W = $clog2(PIX_PER_WORD) (3 at defaults)
- Ports:
  - clk_25  in  1  pixel clock
  - rst_n  in  1  asynchronous, active-low reset
  - disp_active  in  1  high during visible pixels
  - line_end  in  1  one-cycle pulse after each scanline
  - frame_end  in  1  one-cycle pulse after each frame
  - mem_req  out  1  fetch request; held until acknowledged
  - mem_addr  out  ADDR_W  word address of requested pixel
  - mem_pix_sel  out  SEL_W  pixel index within word
  - mem_ack  in  1  request accepted; mem_data valid this cycle
  - mem_data  in  PIX_W  requested pixel
  - pixel_out  out  PIX_W  registered output pixel
  - underrun  out  1  pulse: displayed row not yet fully fetched

## Operation
- Counters:
  - h_cnt (0..SCALE_X-1) and h_pix (0..COLS-1) advance on each disp_active cycle; both clear on line_end.
  - v_cnt (0..SCALE_Y-1) advances on line_end. On wrap, v_pix increments.
  - v_pix saturates at ROWS, meaning past the image. From then on pixel_out = 0 and underrun stays 0.
  - frame_end clears v_cnt, v_pix, h_cnt, h_pix.
- Banks: row r is stored in and displayed from bank r[0]. A display swap is implicit in v_pix changing.
- Fetch engine states:
  - IDLE → FETCH when fetch_row ≤ v_pix+1 and fetch_row < ROWS.
  - FETCH issues COLS requests, col 0..COLS-1. On each mem_ack it writes mem_data to bank fetch_row[0][col].
  - After the ack for col COLS-1, it sets ready[fetch_row[0]], increments fetch_row, and returns to IDLE, or stays in FETCH if the condition still holds.
  - Starting a row clears that bank's ready bit.
- Address: linear = fetch_row*COLS + col; mem_addr = linear / PIX_PER_WORD; mem_pix_sel = linear % PIX_PER_WORD.
- frame_end:
  - Sets fetch_row = 0 and clears both ready bits.
  - If a request is outstanding, mem_req and the address stay held until mem_ack. That data is discarded, then fetching restarts at row 0, col 0.
  - Requests are never withdrawn except by rst_n.
- Display:
  - If ready[v_pix[0]] is set: pixel_out = bank[v_pix[0]][h_pix].
  - If it is clear: pixel_out = 0 and underrun = 1 for that pixel.
  - Outside disp_active: pixel_out = 0.
- line_end and frame_end in the same cycle: frame_end wins.

## Timing
- Reset (async, rst_n low): mem_req 0, mem_addr 0, mem_pix_sel 0, pixel_out 0, underrun 0, state IDLE, counters 0, fetch_row 0, ready bits 0.
- Memory handshake:
  - mem_req rises the cycle after the IDLE→FETCH condition is true.
  - A transfer occurs on any cycle with mem_req & mem_ack, including the first cycle of mem_req (zero-wait).
  - After an ack, the address updates the next cycle and mem_req stays high, so one pixel per cycle is possible.
  - A row takes COLS cycles minimum (64 at defaults).
- Display latency:
  - pixel_out and underrun are registered. The pixel for the nth disp_active cycle of a line appears in cycle n+1.
  - Each framebuffer pixel is held for exactly SCALE_X cycles.
- Row prefetch: fetch of row v_pix+1 starts the cycle after the line_end that advances v_pix. At defaults this leaves SCALE_Y·800 cycles for COLS acks.
- After frame_end, rows 0 and 1 are fetched back to back (2·COLS acks minimum). Then the engine idles until v_pix advances.

## Test plan
- Reset and idle: hold rst_n low mid-fetch → mem_req, pixel_out and underrun go 0 immediately; after release with no frame_end, mem_req rises, fetching row 0 from addr 0.
- Frame prefetch: frame_end with mem_ack tied high → 128 consecutive acks, mem_addr 0..15 with mem_pix_sel cycling 0..7, then mem_req low.
- Horizontal scaling: row 0 holds pixel c = c mod 16; 640 disp_active cycles → pixel_out steps 0,1,…,15,0… with each value held 10 cycles, starting one cycle after disp_active rises.
- Vertical advance: after the 10th line_end → row 1 displayed from bank 1, mem_req rises next cycle with mem_addr 16. After 480 lines → pixel_out 0 and no underrun.
- Underrun: mem_ack held low after frame_end, then disp_active → pixel_out 0 and underrun 1 on every active cycle. Releasing ack mid-line leaves underrun set until row 0 completes.
- Frame restart: frame_end while mem_req pending at addr 9 → addr 9 held until ack, then mem_addr 0, mem_pix_sel 0 on the next request.

Source files
------------

// File: rtl/pixel_line_feeder.sv
// pixel_line_feeder: fetches framebuffer rows into two ping-pong line banks and
// streams them out with SCALE_X x SCALE_Y pixel replication.
module pixel_line_feeder #(
    parameter int unsigned PIX_W        = 4,
    parameter int unsigned COLS         = 64,
    parameter int unsigned ROWS         = 48,
    parameter int unsigned SCALE_X      = 10,
    parameter int unsigned SCALE_Y      = 10,
    parameter int unsigned PIX_PER_WORD = 8,
    parameter int unsigned ADDR_W       = $clog2(COLS * ROWS / PIX_PER_WORD),
    parameter int unsigned SEL_W        = $clog2(PIX_PER_WORD)
) (
    input  logic              clk_25,
    input  logic              rst_n,
    input  logic              disp_active,
    input  logic              line_end,
    input  logic              frame_end,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [SEL_W-1:0]  mem_pix_sel,
    input  logic              mem_ack,
    input  logic [PIX_W-1:0]  mem_data,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              underrun
);

    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ROW_W = $clog2(ROWS + 1);
    localparam int unsigned ROW_X = ROW_W + 1;
    localparam int unsigned HC_W  = $clog2(SCALE_X);
    localparam int unsigned VC_W  = $clog2(SCALE_Y + 1);
    localparam int unsigned LIN_W = ADDR_W + SEL_W;

    typedef enum logic {IDLE, FETCH} state_e;

    state_e             state_q, state_d;
    logic [HC_W-1:0]    h_cnt_q, h_cnt_d;
    logic [COL_W-1:0]   h_pix_q, h_pix_d;
    logic [VC_W-1:0]    v_cnt_q, v_cnt_d;
    logic [ROW_W-1:0]   v_pix_q, v_pix_d;
    logic [ROW_W-1:0]   fetch_row_q, fetch_row_d, next_row;
    logic [COL_W-1:0]   col_q, col_d;
    logic [1:0]         ready_q, ready_d;
    logic               discard_q, discard_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [SEL_W-1:0]   mem_sel_q, mem_sel_d;
    logic [PIX_W-1:0]   pixel_q, pixel_d;
    logic               underrun_q, underrun_d;
    logic               wr_en, last_col;
    logic [PIX_W-1:0]   bank_q [2][COLS];

    // A row may be fetched once the displayed row is at most one behind it.
    function automatic logic can_start(input logic [ROW_W-1:0] row, input logic [ROW_W-1:0] vp);
        return (ROW_X'(row) <= ROW_X'(vp) + ROW_X'(1)) && (row < ROW_W'(ROWS));
    endfunction

    // Linear pixel index; upper bits are the word address, lower bits the pixel select.
    function automatic logic [LIN_W-1:0] lin_of(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
        return LIN_W'(row) * LIN_W'(COLS) + LIN_W'(col);
    endfunction

    assign next_row = fetch_row_q + ROW_W'(1);
    assign last_col = (col_q == COL_W'(COLS - 1));

    // Raster counters: horizontal replication/column, vertical replication/row.
    always_comb begin
        h_cnt_d = h_cnt_q;
        h_pix_d = h_pix_q;
        v_cnt_d = v_cnt_q;
        v_pix_d = v_pix_q;
        if (frame_end) begin
            h_cnt_d = '0;
            h_pix_d = '0;
            v_cnt_d = '0;
            v_pix_d = '0;
        end else if (line_end) begin
            h_cnt_d = '0;
            h_pix_d = '0;
            if (v_cnt_q == VC_W'(SCALE_Y - 1)) begin
                v_cnt_d = '0;
                if (v_pix_q != ROW_W'(ROWS)) v_pix_d = v_pix_q + ROW_W'(1);
            end else begin
                v_cnt_d = v_cnt_q + VC_W'(1);
            end
        end else if (disp_active) begin
            if (h_cnt_q == HC_W'(SCALE_X - 1)) begin
                h_cnt_d = '0;
                h_pix_d = h_pix_q + COL_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + HC_W'(1);
            end
        end
    end

    // Fetch FSM state register.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Fetch FSM next state; an outstanding request is held across frame_end until acked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!frame_end && can_start(fetch_row_q, v_pix_d)) state_d = FETCH;
            end
            FETCH: begin
                if (mem_ack) begin
                    if (frame_end || discard_q)                      state_d = IDLE;
                    else if (last_col && !can_start(next_row, v_pix_d)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetch FSM outputs: request/address generation, bank writes, ready bits.
    always_comb begin
        fetch_row_d = fetch_row_q;
        col_d       = col_q;
        ready_d     = ready_q;
        discard_d   = discard_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_sel_d   = mem_sel_q;
        wr_en       = 1'b0;
        if (frame_end) begin
            fetch_row_d = '0;
            col_d       = '0;
            ready_d     = '0;
            if (state_q == FETCH && !mem_ack) begin
                discard_d = 1'b1;
            end else begin
                discard_d = 1'b0;
                mem_req_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (state_d == FETCH) begin
                        mem_req_d                 = 1'b1;
                        {mem_addr_d, mem_sel_d}   = lin_of(fetch_row_q, COL_W'(0));
                        ready_d[fetch_row_q[0]]   = 1'b0;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            mem_req_d = 1'b0;
                        end else begin
                            wr_en = 1'b1;
                            if (last_col) begin
                                ready_d[fetch_row_q[0]] = 1'b1;
                                fetch_row_d             = next_row;
                                col_d                   = '0;
                                if (state_d == FETCH) begin
                                    ready_d[next_row[0]]    = 1'b0;
                                    {mem_addr_d, mem_sel_d} = lin_of(next_row, COL_W'(0));
                                end else begin
                                    mem_req_d = 1'b0;
                                end
                            end else begin
                                col_d                   = col_q + COL_W'(1);
                                {mem_addr_d, mem_sel_d} = lin_of(fetch_row_q, col_q + COL_W'(1));
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Displayed pixel: bank lookup when the row is ready, blank past the image.
    always_comb begin
        pixel_d    = '0;
        underrun_d = 1'b0;
        if (disp_active && v_pix_q != ROW_W'(ROWS)) begin
            if (ready_q[v_pix_q[0]]) pixel_d    = bank_q[v_pix_q[0]][h_pix_q];
            else                     underrun_d = 1'b1;
        end
    end

    // Counter, fetch datapath and output registers.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q     <= '0;
            h_pix_q     <= '0;
            v_cnt_q     <= '0;
            v_pix_q     <= '0;
            fetch_row_q <= '0;
            col_q       <= '0;
            ready_q     <= '0;
            discard_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_sel_q   <= '0;
            pixel_q     <= '0;
            underrun_q  <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            h_pix_q     <= h_pix_d;
            v_cnt_q     <= v_cnt_d;
            v_pix_q     <= v_pix_d;
            fetch_row_q <= fetch_row_d;
            col_q       <= col_d;
            ready_q     <= ready_d;
            discard_q   <= discard_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_sel_q   <= mem_sel_d;
            pixel_q     <= pixel_d;
            underrun_q  <= underrun_d;
        end
    end

    // Line bank storage; row r lands in bank r[0].
    always_ff @(posedge clk_25) begin
        if (wr_en) bank_q[fetch_row_q[0]][col_q] <= mem_data;
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign mem_pix_sel = mem_sel_q;
    assign pixel_out   = pixel_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_pixel_line_feeder.sv
// Directed self-checking bench for pixel_line_feeder at default parameters.
`timescale 1ns/1ps
module tb_pixel_line_feeder;

    localparam int PIX_W  = 4;
    localparam int COLS   = 64;
    localparam int SCALE  = 10;
    localparam int ADDR_W = 9;
    localparam int SEL_W  = 3;

    logic              clk_25 = 1'b0;
    logic              rst_n, disp_active, line_end, frame_end, mem_ack;
    logic              mem_req, underrun;
    logic [ADDR_W-1:0] mem_addr;
    logic [SEL_W-1:0]  mem_pix_sel;
    logic [PIX_W-1:0]  mem_data, pixel_out;
    logic [11:0]       lin_now;

    int errors = 0;
    int checks = 0;
    int n, started, unr_seen;

    pixel_line_feeder dut (
        .clk_25      (clk_25),
        .rst_n       (rst_n),
        .disp_active (disp_active),
        .line_end    (line_end),
        .frame_end   (frame_end),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_pix_sel (mem_pix_sel),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .pixel_out   (pixel_out),
        .underrun    (underrun)
    );

    always #20 clk_25 = ~clk_25;

    // Framebuffer content model.
    function automatic logic [PIX_W-1:0] pix(input int row, input int col);
        return PIX_W'((col + 5 * row) % 16);
    endfunction

    assign lin_now  = {mem_addr, mem_pix_sel};
    assign mem_data = pix(int'(lin_now) / COLS, int'(lin_now) % COLS);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    task automatic pulse_line();
        line_end = 1'b1;
        tick();
        line_end = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic wait_req(input logic lvl, input int bound, input string tag);
        int i = 0;
        while (mem_req !== lvl && i < bound) begin
            tick();
            i++;
        end
        chk(tag, 32'(mem_req === lvl), 32'd1);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; disp_active = 1'b0; line_end = 1'b0; frame_end = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        chk("rst_req",  32'(mem_req), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_sel",  32'(mem_pix_sel), 0);
        chk("rst_pix",  32'(pixel_out), 0);
        chk("rst_unr",  32'(underrun), 0);

        // Release: row 0 fetch starts at address 0 without frame_end.
        rst_n = 1'b1;
        tick();
        chk("rel_req",  32'(mem_req), 1);
        chk("rel_addr", 32'(mem_addr), 0);
        chk("rel_sel",  32'(mem_pix_sel), 0);
        tick();
        chk("rel_hold", 32'(lin_now), 0);

        // Five acks, then asynchronous reset mid-fetch.
        mem_ack = 1'b1;
        repeat (5) tick();
        chk("mid_sel", 32'(mem_pix_sel), 5);
        mem_ack = 1'b0;
        #5 rst_n = 1'b0;
        #1;
        chk("async_req", 32'(mem_req), 0);
        chk("async_sel", 32'(mem_pix_sel), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel2_req", 32'(mem_req), 1);

        // Frame prefetch: rows 0 and 1 back to back with ack held high.
        mem_ack = 1'b1;
        pulse_frame();
        n = 0; started = 0;
        for (int i = 0; i < 400; i++) begin
            if (mem_req) begin
                started = 1;
                chk("pf_word", 32'(lin_now), 32'(n));
                n++;
            end else if (started != 0) begin
                break;
            end
            tick();
        end
        chk("pf_count", 32'(n), 128);
        tick();
        chk("pf_idle", 32'(mem_req), 0);

        // Horizontal replication of row 0.
        unr_seen = 0;
        disp_active = 1'b1;
        for (int k = 0; k < 640; k++) begin
            tick();
            chk("hs_pix", 32'(pixel_out), 32'(pix(0, k / SCALE)));
            if (underrun) unr_seen++;
        end
        disp_active = 1'b0;
        chk("hs_unr", 32'(unr_seen), 0);
        tick();
        chk("hs_off", 32'(pixel_out), 0);

        // Vertical advance on the 10th line_end.
        for (int l = 0; l < 9; l++) begin
            pulse_line();
            tick();
        end
        chk("va_pre_req", 32'(mem_req), 0);
        pulse_line();
        chk("va_req",  32'(mem_req), 1);
        chk("va_addr", 32'(mem_addr), 16);
        chk("va_sel",  32'(mem_pix_sel), 0);
        disp_active = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("va_pix", 32'(pixel_out), 32'(pix(1, k / SCALE)));
            chk("va_unr", 32'(underrun), 0);
        end
        disp_active = 1'b0;
        tick();

        // Past the image: blank and no underrun, also once more lines have gone by.
        for (int l = 0; l < 470; l++) begin
            pulse_line();
            tick();
        end
        wait_req(1'b0, 5000, "sat_idle");
        for (int pass = 0; pass < 2; pass++) begin
            disp_active = 1'b1;
            for (int k = 0; k < 10; k++) begin
                tick();
                chk("sat_pix", 32'(pixel_out), 0);
                chk("sat_unr", 32'(underrun), 0);
            end
            disp_active = 1'b0;
            tick();
            for (int l = 0; l < 10; l++) begin
                pulse_line();
                tick();
            end
        end

        // Underrun: ack withheld after frame_end, released mid-line.
        mem_ack = 1'b0;
        pulse_frame();
        tick();
        disp_active = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("ur_pix",  32'(pixel_out), 0);
            chk("ur_flag", 32'(underrun), 1);
        end
        mem_ack = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k <= 64) begin
                chk("ur_hold_flag", 32'(underrun), 1);
                chk("ur_hold_pix",  32'(pixel_out), 0);
            end else begin
                chk("ur_done_flag", 32'(underrun), 0);
                chk("ur_done_pix",  32'(pixel_out), 32'(pix(0, (29 + k) / SCALE)));
            end
        end
        disp_active = 1'b0;

        // Frame restart while a request at address 9 is pending.
        pulse_frame();
        n = 0;
        while (!(mem_req && mem_addr == 9) && n < 300) begin
            tick();
            n++;
        end
        mem_ack = 1'b0;
        chk("fr_reach", 32'(lin_now), 72);
        pulse_frame();
        chk("fr_req",  32'(mem_req), 1);
        chk("fr_addr", 32'(mem_addr), 9);
        chk("fr_sel",  32'(mem_pix_sel), 0);
        repeat (3) tick();
        chk("fr_hold", 32'(mem_addr), 9);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        wait_req(1'b1, 10, "fr_rereq");
        chk("fr_new_addr", 32'(mem_addr), 0);
        chk("fr_new_sel",  32'(mem_pix_sel), 0);
        disp_active = 1'b1;
        tick();
        chk("fr_unr", 32'(underrun), 1);
        disp_active = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
